// File: rtl/sparc_exu_alu_pkg.sv
// Shared opcode and condition-code definitions
// for the pipelined EXU integer ALU.
package sparc_exu_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_AND   = 3'd1,
    OP_OR    = 3'd2,
    OP_XOR   = 3'd3,
    OP_MOVE  = 3'd4,
    OP_RS3   = 3'd5,
    OP_SETHI = 3'd6,
    OP_RSV   = 3'd7
  } alu_op_e;

  localparam int CCR_XN = 7;
  localparam int CCR_XZ = 6;
  localparam int CCR_XV = 5;
  localparam int CCR_XC = 4;
  localparam int CCR_IN = 3;
  localparam int CCR_IZ = 2;
  localparam int CCR_IV = 1;
  localparam int CCR_IC = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } cc_t;

  function automatic logic [7:0] ccr_pack(
    input cc_t xcc,
    input cc_t icc
  );
    return {xcc, icc};
  endfunction

endpackage

// File: rtl/sparc_exu_alu_obuf.sv
// Synchronous output FIFO with flush; holds the
// last popped entry on its read port when empty.
module sparc_exu_alu_obuf #(
  parameter int W     = 121,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         wr_vld,
  output logic         wr_rdy,
  input  logic [W-1:0] wr_data,
  input  logic         flush,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [W-1:0]  hold_q;
  logic          push;
  logic          pop;

  assign wr_rdy = count < CW'(DEPTH);
  assign rd_vld = count != '0;
  assign push   = wr_vld & wr_rdy & ~flush;
  assign pop    = rd_vld & rd_rdy & ~flush;

  assign rd_data = rd_vld ? mem[rd_ptr] : hold_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold_q <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        hold_q <= mem[rd_ptr];
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sparc_exu_alu_pipe.sv
// EXU integer ALU: combinational compute of result,
// VA and icc/xcc, buffered through a skid FIFO.
module sparc_exu_alu_pipe
  import sparc_exu_alu_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int VA_BITS = 48,
  parameter int DEPTH   = 2
) (
  input  logic               rclk,
  input  logic               rst_l,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [2:0]         in_op,
  input  logic               in_invert,
  input  logic               in_cin,
  input  logic               in_casa,
  input  logic [DATA_W-1:0]  in_rs1,
  input  logic [DATA_W-1:0]  in_rs2,
  input  logic [DATA_W-1:0]  in_rs3,
  input  logic               flush,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [DATA_W-1:0]  out_data,
  output logic [VA_BITS-1:0] out_va,
  output logic [7:0]         out_ccr,
  output logic               out_va_bad
);

  localparam int H  = DATA_W / 2;
  localparam int EW = DATA_W + VA_BITS + 9;
  localparam int HW = DATA_W - VA_BITS + 1;

  alu_op_e           op;
  logic [DATA_W-1:0] b;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] res;
  logic [DATA_W-1:0] va_full;
  logic [HW-1:0]     va_hi;
  logic              va_bad;
  logic              c_mid;
  cc_t               xcc;
  cc_t               icc;
  logic [EW-1:0]     wr_data;
  logic [EW-1:0]     rd_data;

  always_comb begin
    op  = alu_op_e'(in_op);
    b   = in_invert ? ~in_rs2 : in_rs2;
    sum = {1'b0, in_rs1} + {1'b0, b}
        + {{DATA_W{1'b0}}, in_cin};
    res = '0;
    unique case (op)
      OP_ADD:   res = sum[DATA_W-1:0];
      OP_AND:   res = in_rs1 & b;
      OP_OR:    res = in_rs1 | b;
      OP_XOR:   res = in_rs1 ^ b;
      OP_MOVE:  res = b;
      OP_RS3:   res = in_rs3;
      OP_SETHI: res = {{(DATA_W-H){1'b0}}, in_rs2[H-1:0]};
      OP_RSV:   res = '0;
    endcase
  end

  // carry out of the low half is the carry into bit H
  assign c_mid = sum[H] ^ in_rs1[H] ^ b[H];

  always_comb begin
    xcc = '0;
    icc = '0;
    if (op != OP_RSV) begin
      xcc.n = res[DATA_W-1];
      xcc.z = ~|res;
      icc.n = res[H-1];
      icc.z = ~|res[H-1:0];
    end
    if (op == OP_ADD) begin
      xcc.c = sum[DATA_W];
      xcc.v = (in_rs1[DATA_W-1] == b[DATA_W-1])
            & (res[DATA_W-1] != in_rs1[DATA_W-1]);
      icc.c = c_mid;
      icc.v = (in_rs1[H-1] == b[H-1])
            & (res[H-1] != in_rs1[H-1]);
    end
  end

  assign va_full = in_casa ? in_rs1 : sum[DATA_W-1:0];
  assign va_hi   = va_full[DATA_W-1:VA_BITS-1];
  assign va_bad  = ~(&va_hi | ~|va_hi);

  assign wr_data = {res, va_full[VA_BITS-1:0],
                    ccr_pack(xcc, icc), va_bad};

  sparc_exu_alu_obuf #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_obuf (
    .clk     (rclk),
    .rst_l   (rst_l),
    .wr_vld  (in_vld),
    .wr_rdy  (in_rdy),
    .wr_data (wr_data),
    .flush   (flush),
    .rd_vld  (out_vld),
    .rd_rdy  (out_rdy),
    .rd_data (rd_data)
  );

  assign out_data   = rd_data[EW-1 -: DATA_W];
  assign out_va     = rd_data[VA_BITS+8 -: VA_BITS];
  assign out_ccr    = rd_data[8:1];
  assign out_va_bad = rd_data[0];

endmodule

// File: tb/tb_sparc_exu_alu_pipe.sv
// Bench for sparc_exu_alu_pipe: fixed vectors, queue
// model with random traffic, and a 32-bit/4-deep instance.
module tb_sparc_exu_alu_pipe;

  logic rclk = 1'b0;
  always #5 rclk = ~rclk;

  logic        a_rst_l, a_in_vld, a_in_rdy;
  logic [2:0]  a_in_op;
  logic        a_in_invert, a_in_cin, a_in_casa;
  logic [63:0] a_rs1, a_rs2, a_rs3;
  logic        a_flush, a_out_vld, a_out_rdy;
  logic [63:0] a_out_data;
  logic [47:0] a_out_va;
  logic [7:0]  a_out_ccr;
  logic        a_out_va_bad;

  logic        b_rst_l, b_in_vld, b_in_rdy;
  logic [2:0]  b_in_op;
  logic        b_in_invert, b_in_cin, b_in_casa;
  logic [31:0] b_rs1, b_rs2, b_rs3;
  logic        b_flush, b_out_vld, b_out_rdy;
  logic [31:0] b_out_data;
  logic [31:0] b_out_va;
  logic [7:0]  b_out_ccr;
  logic        b_out_va_bad;

  sparc_exu_alu_pipe #(
    .DATA_W(64), .VA_BITS(48), .DEPTH(2)
  ) dut_a (
    .rclk(rclk), .rst_l(a_rst_l),
    .in_vld(a_in_vld), .in_rdy(a_in_rdy),
    .in_op(a_in_op), .in_invert(a_in_invert),
    .in_cin(a_in_cin), .in_casa(a_in_casa),
    .in_rs1(a_rs1), .in_rs2(a_rs2), .in_rs3(a_rs3),
    .flush(a_flush), .out_vld(a_out_vld),
    .out_rdy(a_out_rdy), .out_data(a_out_data),
    .out_va(a_out_va), .out_ccr(a_out_ccr),
    .out_va_bad(a_out_va_bad)
  );

  sparc_exu_alu_pipe #(
    .DATA_W(32), .VA_BITS(32), .DEPTH(4)
  ) dut_b (
    .rclk(rclk), .rst_l(b_rst_l),
    .in_vld(b_in_vld), .in_rdy(b_in_rdy),
    .in_op(b_in_op), .in_invert(b_in_invert),
    .in_cin(b_in_cin), .in_casa(b_in_casa),
    .in_rs1(b_rs1), .in_rs2(b_rs2), .in_rs3(b_rs3),
    .flush(b_flush), .out_vld(b_out_vld),
    .out_rdy(b_out_rdy), .out_data(b_out_data),
    .out_va(b_out_va), .out_ccr(b_out_ccr),
    .out_va_bad(b_out_va_bad)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [63:0] va;
    logic [7:0]  ccr;
    logic        bad;
  } res_t;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic        inv, cin, casa;
    logic [63:0] rs1, rs2, rs3;
    logic [63:0] d;
    logic [47:0] va;
    logic [7:0]  ccr;
    logic        bad;
  } vec_t;

  int tests = 0;
  int fails = 0;
  res_t q[$];
  res_t last;
  vec_t tbl[9];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h",
               name, act, exp);
    end
  endtask

  // Reference: arithmetic on wide unsigned values,
  // masked to width w, flags from their definitions.
  function automatic res_t ref_op(
    input int w, input int vab,
    input logic [2:0] op, input logic inv,
    input logic cin, input logic casa,
    input logic [63:0] a_in, input logic [63:0] b_in,
    input logic [63:0] c_in);
    logic [64:0] m, hm, a, b, c, s, sl, r, va, top, ones;
    logic xn, xz, xv, xc, ln, lz, lv, lc;
    int h, nb;
    res_t o;
    h  = w / 2;
    m  = (65'h1 << w) - 65'h1;
    hm = (65'h1 << h) - 65'h1;
    a  = {1'b0, a_in} & m;
    b  = (inv ? ~{1'b0, b_in} : {1'b0, b_in}) & m;
    c  = {1'b0, c_in} & m;
    s  = a + b + 65'(cin);
    sl = (a & hm) + (b & hm) + 65'(cin);
    case (op)
      3'd0: r = s & m;
      3'd1: r = a & b;
      3'd2: r = a | b;
      3'd3: r = a ^ b;
      3'd4: r = b;
      3'd5: r = c;
      3'd6: r = {1'b0, b_in} & hm;
      default: r = '0;
    endcase
    xn = r[w-1]; xz = (r == 0);
    ln = r[h-1]; lz = ((r & hm) == 0);
    xv = 0; xc = 0; lv = 0; lc = 0;
    if (op == 3'd0) begin
      xc = s[w];
      lc = sl[h];
      xv = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
      lv = (a[h-1] == b[h-1]) && (r[h-1] != a[h-1]);
    end
    if (op == 3'd7) begin
      xn = 0; xz = 0; ln = 0; lz = 0;
    end
    va   = casa ? a : (s & m);
    top  = va >> (vab - 1);
    nb   = w - vab + 1;
    ones = (65'h1 << nb) - 65'h1;
    o.bad  = (top != 0) && (top != ones);
    o.data = r[63:0];
    o.va   = va[63:0] & ((64'h1 << vab) - 64'h1);
    o.ccr  = {xn, xz, xv, xc, ln, lz, lv, lc};
    return o;
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0: return 64'h0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      3: return {32'h0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic a_check_head();
    res_t e;
    e = (q.size() != 0) ? q[0] : last;
    chk("a_out_vld", 64'(a_out_vld), 64'(q.size() != 0));
    chk("a_in_rdy", 64'(a_in_rdy), 64'(q.size() < 2));
    chk("a_out_data", a_out_data, e.data);
    chk("a_out_va", 64'(a_out_va), e.va);
    chk("a_out_ccr", 64'(a_out_ccr), 64'(e.ccr));
    chk("a_out_va_bad", 64'(a_out_va_bad), 64'(e.bad));
  endtask

  // One cycle on instance A: check, drive, update model.
  task automatic a_step(
    input logic vld, input logic rdy, input logic fl,
    input logic [2:0] op, input logic inv,
    input logic cin, input logic casa,
    input logic [63:0] r1, input logic [63:0] r2,
    input logic [63:0] r3);
    logic acc, pop;
    a_check_head();
    a_in_vld = vld; a_out_rdy = rdy; a_flush = fl;
    a_in_op = op; a_in_invert = inv;
    a_in_cin = cin; a_in_casa = casa;
    a_rs1 = r1; a_rs2 = r2; a_rs3 = r3;
    acc = vld && (q.size() < 2);
    pop = rdy && (q.size() != 0);
    if (fl) begin
      q.delete();
    end else begin
      if (pop) last = q.pop_front();
      if (acc) q.push_back(ref_op(64, 48, op, inv, cin,
                                  casa, r1, r2, r3));
    end
    @(posedge rclk);
    #1;
  endtask

  task automatic a_idle(input logic rdy);
    a_step(1'b0, rdy, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0,
           64'h0, 64'h0, 64'h0);
  endtask

  task automatic a_add(input logic rdy, input logic [63:0] v);
    a_step(1'b1, rdy, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0,
           v, 64'h1, 64'h0);
  endtask

  initial begin
    res_t eb;
    tbl[0] = '{"add_ovf", 3'd0, 0, 0, 0,
      64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h0,
      64'h8000_0000_0000_0000, 48'h0, 8'hA5, 1'b1};
    tbl[1] = '{"sub_eq", 3'd0, 1, 1, 0,
      64'h5, 64'h5, 64'h0,
      64'h0, 48'h0, 8'h55, 1'b0};
    tbl[2] = '{"va_hole", 3'd0, 0, 0, 0,
      64'h0000_7FFF_FFFF_FFF0, 64'h10, 64'h0,
      64'h0000_8000_0000_0000, 48'h8000_0000_0000,
      8'h05, 1'b1};
    tbl[3] = '{"casa_va", 3'd0, 0, 0, 1,
      64'hFFFF_8000_0000_0000, 64'h0, 64'h0,
      64'hFFFF_8000_0000_0000, 48'h8000_0000_0000,
      8'h84, 1'b0};
    tbl[4] = '{"andn", 3'd1, 1, 0, 0,
      64'hF0F0, 64'hFF00, 64'h0,
      64'hF0, 48'hFFFF_FFFF_F1EF, 8'h00, 1'b0};
    tbl[5] = '{"rsv", 3'd7, 0, 0, 0,
      64'h1, 64'h2, 64'h0,
      64'h0, 48'h3, 8'h00, 1'b0};
    tbl[6] = '{"rs3", 3'd5, 0, 0, 0,
      64'h0, 64'h0, 64'h8000_0000_0000_0000,
      64'h8000_0000_0000_0000, 48'h0, 8'h84, 1'b0};
    tbl[7] = '{"sethi", 3'd6, 0, 0, 0,
      64'h0, 64'h1234_5678_DEAD_BEEF, 64'h0,
      64'hDEAD_BEEF, 48'h5678_DEAD_BEEF, 8'h08, 1'b1};
    tbl[8] = '{"not", 3'd4, 1, 0, 0,
      64'h0, 64'h0, 64'h0,
      64'hFFFF_FFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF,
      8'h88, 1'b0};

    a_rst_l = 0; a_in_vld = 0; a_in_op = 0;
    a_in_invert = 0; a_in_cin = 0; a_in_casa = 0;
    a_rs1 = 0; a_rs2 = 0; a_rs3 = 0;
    a_flush = 0; a_out_rdy = 0;
    b_rst_l = 0; b_in_vld = 0; b_in_op = 0;
    b_in_invert = 0; b_in_cin = 0; b_in_casa = 0;
    b_rs1 = 0; b_rs2 = 0; b_rs3 = 0;
    b_flush = 0; b_out_rdy = 0;
    last = '0;
    repeat (2) @(posedge rclk);
    #1;
    chk("rst_out_vld", 64'(a_out_vld), 64'h0);
    chk("rst_out_data", a_out_data, 64'h0);
    chk("rst_out_ccr", 64'(a_out_ccr), 64'h0);
    a_rst_l = 1; b_rst_l = 1;
    @(posedge rclk);
    #1;
    chk("rst_in_rdy", 64'(a_in_rdy), 64'h1);

    foreach (tbl[i]) begin
      a_step(1'b1, 1'b1, 1'b0, tbl[i].op, tbl[i].inv,
             tbl[i].cin, tbl[i].casa,
             tbl[i].rs1, tbl[i].rs2, tbl[i].rs3);
      chk({tbl[i].name, "_vld"}, 64'(a_out_vld), 64'h1);
      chk({tbl[i].name, "_data"}, a_out_data, tbl[i].d);
      chk({tbl[i].name, "_va"}, 64'(a_out_va),
          64'(tbl[i].va));
      chk({tbl[i].name, "_ccr"}, 64'(a_out_ccr),
          64'(tbl[i].ccr));
      chk({tbl[i].name, "_bad"}, 64'(a_out_va_bad),
          64'(tbl[i].bad));
    end
    a_idle(1'b1);
    a_idle(1'b1);

    // backpressure: two accepted, third held until a slot frees
    a_add(1'b0, 64'h100);
    a_add(1'b0, 64'h200);
    chk("bp_in_rdy_low", 64'(a_in_rdy), 64'h0);
    a_add(1'b0, 64'h300);
    a_add(1'b1, 64'h300);
    a_add(1'b1, 64'h300);
    a_idle(1'b1);
    a_idle(1'b1);
    chk("bp_last_data", a_out_data, 64'h301);

    // flush while full with a push pending
    a_add(1'b0, 64'h400);
    a_add(1'b0, 64'h500);
    a_step(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0,
           64'h600, 64'h1, 64'h0);
    chk("fl_out_vld", 64'(a_out_vld), 64'h0);
    chk("fl_in_rdy", 64'(a_in_rdy), 64'h1);
    a_idle(1'b1);
    a_idle(1'b1);

    for (int i = 0; i < 400; i++) begin
      a_step($urandom_range(0, 3) != 0,
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 39) == 0,
             3'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), rnd64(), rnd64(), rnd64());
    end
    a_step(1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0,
           64'h0, 64'h0, 64'h0);
    a_idle(1'b1);

    // 32-bit, 4-deep instance: SETHI and mid-stream reset
    b_in_vld = 1; b_out_rdy = 0;
    b_in_op = 3'd6; b_rs1 = 32'h0; b_rs2 = 32'hDEAD_BEEF;
    @(posedge rclk);
    #1;
    eb = ref_op(32, 32, 3'd6, 1'b0, 1'b0, 1'b0,
                64'h0, 64'hDEAD_BEEF, 64'h0);
    chk("b_sethi_vld", 64'(b_out_vld), 64'h1);
    chk("b_sethi_data", 64'(b_out_data), 64'h0000_BEEF);
    chk("b_sethi_ccr", 64'(b_out_ccr), 64'h08);
    chk("b_sethi_va", 64'(b_out_va), eb.va);
    chk("b_sethi_bad", 64'(b_out_va_bad), 64'(eb.bad));
    b_in_op = 3'd0; b_rs1 = 32'h1; b_rs2 = 32'h1;
    @(posedge rclk);
    #1;
    b_rs1 = 32'h2; b_rs2 = 32'h2;
    @(posedge rclk);
    #1;
    b_in_vld = 0;
    chk("b_3_vld", 64'(b_out_vld), 64'h1);
    chk("b_3_in_rdy", 64'(b_in_rdy), 64'h1);
    chk("b_3_head", 64'(b_out_data), 64'h0000_BEEF);
    b_rst_l = 0;
    @(posedge rclk);
    #1;
    b_rst_l = 1;
    chk("b_rst_vld", 64'(b_out_vld), 64'h0);
    chk("b_rst_data", 64'(b_out_data), 64'h0);
    chk("b_rst_va", 64'(b_out_va), 64'h0);
    chk("b_rst_ccr", 64'(b_out_ccr), 64'h0);
    chk("b_rst_bad", 64'(b_out_va_bad), 64'h0);
    chk("b_rst_in_rdy", 64'(b_in_rdy), 64'h1);
    b_out_rdy = 1;
    @(posedge rclk);
    #1;
    chk("b_post_vld", 64'(b_out_vld), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
